// File: rtl/fifo_sseg_if.sv
// Signal bundle between the FIFO lab top level and its seven-segment display driver.
// The FIFO side drives the data/flag inputs; the display driver owns the segment and anode outputs.
interface fifo_sseg_if #(
    parameter int DW = 4
);
    logic [DW-1:0] wdat_i;
    logic [DW-1:0] rdat_i;
    logic          full_i;
    logic          empty_i;
    logic [6:0]    seg_o;
    logic          dp_o;
    logic [3:0]    an_o;

    modport master (
        output wdat_i, rdat_i, full_i, empty_i,
        input  seg_o, dp_o, an_o
    );

    modport slave (
        input  wdat_i, rdat_i, full_i, empty_i,
        output seg_o, dp_o, an_o
    );
endinterface

// File: rtl/fifo_sseg.sv
// Four-digit multiplexed seven-segment driver for the FIFO lab: shows write data, read data,
// a blinking 'F' for full and an 'E' for empty, with one blank clock at every digit change.
module fifo_sseg #(
    parameter int DW        = 4,
    parameter int REFRESH_N = 16,
    parameter int BLINK_N   = 24
) (
    input  logic          clk_i,
    input  logic          rst_i,
    fifo_sseg_if.slave    bus
);
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    logic [DW-1:0]        wdat_m, wdat_s;
    logic [DW-1:0]        rdat_m, rdat_s;
    logic                 full_m, full_s;
    logic                 empty_m, empty_s;
    logic [REFRESH_N-1:0] cnt;
    logic [BLINK_N-1:0]   bcnt;
    logic [1:0]           idx;
    logic                 blink;
    logic                 slot_end;
    logic [3:0]           wdat_hex, rdat_hex;
    logic [6:0]           seg_nxt;
    logic                 dp_nxt;
    logic [3:0]           an_nxt;
    logic [6:0]           seg_q;
    logic                 dp_q;
    logic [3:0]           an_q;

    function automatic logic [6:0] hex_seg(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    // Data is display-only, so per-bit synchronisers are enough; word skew just flickers briefly.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wdat_m  <= '0;
            wdat_s  <= '0;
            rdat_m  <= '0;
            rdat_s  <= '0;
            full_m  <= 1'b0;
            full_s  <= 1'b0;
            empty_m <= 1'b0;
            empty_s <= 1'b0;
        end else begin
            wdat_m  <= bus.wdat_i;
            wdat_s  <= wdat_m;
            rdat_m  <= bus.rdat_i;
            rdat_s  <= rdat_m;
            full_m  <= bus.full_i;
            full_s  <= full_m;
            empty_m <= bus.empty_i;
            empty_s <= empty_m;
        end
    end

    assign slot_end = &cnt;
    assign blink    = bcnt[BLINK_N-1];

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cnt  <= '0;
            bcnt <= '0;
            idx  <= 2'd0;
        end else begin
            cnt  <= cnt + 1'b1;
            bcnt <= bcnt + 1'b1;
            if (slot_end) begin
                idx <= idx + 2'd1;
            end
        end
    end

    assign wdat_hex = 4'(wdat_s);
    assign rdat_hex = 4'(rdat_s);

    always_comb begin
        seg_nxt = SEG_BLANK;
        dp_nxt  = 1'b1;
        an_nxt  = ~(4'b0001 << idx);
        case (idx)
            2'd3: seg_nxt = hex_seg(wdat_hex);
            2'd2: begin
                seg_nxt = hex_seg(rdat_hex);
                // Full and empty together cannot happen in a healthy FIFO; flag it on the read digit.
                dp_nxt  = ~(full_s & empty_s);
            end
            2'd1: begin
                if (full_s && !blink) begin
                    seg_nxt = hex_seg(4'hF);
                end
            end
            default: begin
                if (empty_s) begin
                    seg_nxt = hex_seg(4'hE);
                end
            end
        endcase
        if (slot_end) begin
            seg_nxt = SEG_BLANK;
            dp_nxt  = 1'b1;
            an_nxt  = 4'b1111;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            seg_q <= SEG_BLANK;
            dp_q  <= 1'b1;
            an_q  <= 4'b1111;
        end else begin
            seg_q <= seg_nxt;
            dp_q  <= dp_nxt;
            an_q  <= an_nxt;
        end
    end

    assign bus.seg_o = seg_q;
    assign bus.dp_o  = dp_q;
    assign bus.an_o  = an_q;
endmodule

// File: tb/tb_fifo_sseg.sv
// Directed bench for fifo_sseg with a small REFRESH/BLINK size; expected display words come from
// an edge-count model and are pushed to a scoreboard queue, then popped against the DUT outputs.
module tb_fifo_sseg;
    localparam int RN   = 3;
    localparam int BN   = 5;
    localparam int SLOT = 1 << RN;
    localparam int SCAN = 4 * SLOT;
    localparam int BPER = 1 << BN;

    typedef struct {
        string      tag;
        logic [11:0] v;
    } exp_t;

    logic clk;
    logic rst_n;
    int   k;
    int   chg_k;
    int   vectors;
    int   miscompares;
    exp_t sbq[$];

    fifo_sseg_if #(.DW(4)) bus ();

    fifo_sseg #(.DW(4), .REFRESH_N(RN), .BLINK_N(BN)) dut (
        .clk_i (clk),
        .rst_i (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edges since reset release; the edge just taken is number k.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) k <= 0;
        else        k <= k + 1;
    end

    function automatic logic [6:0] hex7(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'h40;  4'h1: s = 7'h79;  4'h2: s = 7'h24;  4'h3: s = 7'h30;
            4'h4: s = 7'h19;  4'h5: s = 7'h12;  4'h6: s = 7'h02;  4'h7: s = 7'h78;
            4'h8: s = 7'h00;  4'h9: s = 7'h10;  4'hA: s = 7'h08;  4'hB: s = 7'h03;
            4'hC: s = 7'h46;  4'hD: s = 7'h21;  4'hE: s = 7'h06;  default: s = 7'h0E;
        endcase
        return s;
    endfunction

    // Display word {an, seg, dp} after edge kk, given settled input values.
    function automatic logic [11:0] model(input int kk, input logic [3:0] w, input logic [3:0] r,
                                          input logic f, input logic e);
        int         c, d;
        logic       b;
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        c   = (kk - 1) % SLOT;
        d   = ((kk - 1) / SLOT) % 4;
        b   = ((kk - 1) % BPER) >= (BPER / 2);
        an  = 4'b1111;
        seg = 7'h7F;
        dp  = 1'b1;
        if (c != SLOT - 1) begin
            an[d] = 1'b0;
            case (d)
                0: if (e) seg = hex7(4'hE);
                1: if (f && !b) seg = hex7(4'hF);
                2: begin seg = hex7(r); dp = !(f && e); end
                default: seg = hex7(w);
            endcase
        end
        return {an, seg, dp};
    endfunction

    task automatic push(input string tag, input logic [11:0] v);
        exp_t x;
        x.tag = tag;
        x.v   = v;
        sbq.push_back(x);
    endtask

    task automatic pop_check();
        exp_t       x;
        logic [11:0] got;
        x   = sbq.pop_front();
        got = {bus.an_o, bus.seg_o, bus.dp_o};
        vectors++;
        assert (got === x.v) else begin
            miscompares++;
            $error("FAIL %s k=%0d got an=%b seg=%h dp=%b expected an=%b seg=%h dp=%b",
                   x.tag, k, got[11:8], got[7:1], got[0], x.v[11:8], x.v[7:1], x.v[0]);
        end
    endtask

    task automatic run_check(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (k >= chg_k + 3) begin
                push(tag, model(k, bus.wdat_i, bus.rdat_i, bus.full_i, bus.empty_i));
                pop_check();
            end else if (chg_k == 0) begin
                push(tag, model(k, 4'h0, 4'h0, 1'b0, 1'b0));
                pop_check();
            end
        end
    endtask

    task automatic wait_phase(input int ph, input string tag);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 2 * SCAN && !found; i++) begin
            @(posedge clk);
            #1;
            if ((k - 1) % SCAN == ph) found = 1'b1;
        end
        vectors++;
        assert (found) else begin
            miscompares++;
            $error("FAIL %s phase wait timed out, got k=%0d expected phase %0d", tag, k, ph);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        chg_k       = 0;
        bus.wdat_i  = 4'h3;
        bus.rdat_i  = 4'hA;
        bus.full_i  = 1'b0;
        bus.empty_i = 1'b1;

        repeat (5) begin
            @(negedge clk);
            push("reset_hold", {4'b1111, 7'h7F, 1'b1});
            pop_check();
        end
        rst_n = 1'b1;

        run_check(2 * SCAN, "scan");

        bus.full_i  = 1'b1;
        bus.empty_i = 1'b0;
        chg_k       = k;
        run_check(4 * SCAN, "full_blink");

        wait_phase(3 * SLOT, "latency");
        bus.wdat_i = 4'h7;
        chg_k      = k;
        for (int i = 1; i <= 3; i++) begin
            @(posedge clk);
            #1;
            push("latency", model(k, (i < 3) ? 4'h3 : 4'h7, bus.rdat_i, bus.full_i, bus.empty_i));
            pop_check();
        end

        bus.full_i  = 1'b1;
        bus.empty_i = 1'b1;
        chg_k       = k;
        run_check(2 * SCAN, "illegal");

        wait_phase(2 * SLOT + 3, "mid_reset");
        #4;
        rst_n = 1'b0;
        #1;
        push("mid_reset_async", {4'b1111, 7'h7F, 1'b1});
        pop_check();
        @(negedge clk);
        @(negedge clk);
        push("mid_reset_hold", {4'b1111, 7'h7F, 1'b1});
        pop_check();
        rst_n = 1'b1;
        chg_k = 0;
        run_check(SCAN + SLOT, "restart");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/fifo_sseg.md
# fifo_sseg

Four-digit multiplexed seven-segment display driver for the FIFO lab. It sits directly downstream of the FIFO lab top-level and consumes its write data `dat_i`, read data `dat_o`, and the `full`/`empty` flags. It synchronises these into the board clock domain, decodes them to hex glyphs and status letters, and scans a common-anode display with active-low segments and anodes. A blanking cycle at every digit change suppresses ghosting.

## Interface
- `DW`, 4: FIFO data width. Legal range 1..4; the value is zero-extended to a 4-bit hex digit.
- `REFRESH_N`, 16: digit-scan counter width. Each digit slot lasts 2^REFRESH_N clocks, which is 1.31 ms at 50 MHz.
- `BLINK_N`, 24: blink counter width. The blink phase is the counter MSB.
- `clk_i`  in  1  board clock, 50 MHz. This is the only clock.
- `rst_i`  in  1  reset, asynchronous, active-low.
- `wdat_i`  in  DW  FIFO write data (the switches), asynchronous.
- `rdat_i`  in  DW  FIFO read data (`dat_o`), from the read-clock domain.
- `full_i`  in  1  FIFO full flag, from the write-clock domain.
- `empty_i`  in  1  FIFO empty flag, from the read-clock domain.
- `seg_o`  out  7  segments {g,f,e,d,c,b,a}, active-low, registered.
- `dp_o`  out  1  decimal point, active-low, registered.
- `an_o`  out  4  digit anodes, active-low, registered; `an_o[3]` is the leftmost digit.

## Operation
- **Input synchronisers:** every input bit passes through a 2-flop synchroniser. The synchronised values are `wdat_s`, `rdat_s`, `full_s` and `empty_s`. Data is display-only, so bit-skew across a word is accepted.
- **Scan counter:** `cnt` has REFRESH_N bits, free-runs and wraps to 0.
- **Digit index:** `idx` is 2 bits and increments modulo 4 only when `cnt` is all ones.
- **Blink counter:** `bcnt` has BLINK_N bits and free-runs. Define `blink = bcnt[BLINK_N-1]`.
- **Digit content:**
  - idx 3 shows hex(`wdat_s`).
  - idx 2 shows hex(`rdat_s`).
  - idx 1 shows 'F' when `full_s` is high and `blink` is 0, otherwise blank.
  - idx 0 shows 'E' when `empty_s` is high, otherwise blank. It does not blink.
- **Decimal point:** `dp_o` is 0 only while idx 2 is displayed and `full_s` and `empty_s` are both high (illegal FIFO state). Otherwise `dp_o` is 1.
- **Hex decode (`seg_o`, active-low gfedcba):**
  - 0 = 40, 1 = 79, 2 = 24, 3 = 30
  - 4 = 19, 5 = 12, 6 = 02, 7 = 78
  - 8 = 00, 9 = 10, A = 08, b = 03
  - C = 46, d = 21, E = 06, F = 0E
  - blank = 7F
- **Register update at every rising edge:**
  - If `cnt` is all ones: `an_o` ← 1111, `seg_o` ← 7F, `dp_o` ← 1 (blank cycle), and `idx` ← `idx` + 1.
  - Otherwise: `an_o` ← ~(1 << `idx`), `seg_o` ← decode(content[`idx`]), `dp_o` per the rule above.
- **Reset (asynchronous, `rst_i` = 0):**
  - All counters, `idx` and synchroniser flops clear to 0.
  - `an_o` = 1111, `seg_o` = 7F, `dp_o` = 1.
  - Outputs hold these values for as long as reset is low, including when reset is asserted in the middle of a slot.
- **No state machine beyond the counters:** content is recomputed every cycle, so a change of an input is reflected within its own digit slot.

## Timing
- **Input to segments:** 3 clocks (2 synchroniser stages plus 1 output register), provided the digit is currently active.
- **First edge after reset release:** `an_o` = 1110 and digit 0 is displayed.
- **Slot structure:** each slot is 2^REFRESH_N − 1 active clocks followed by 1 blank clock. A full scan takes 4·2^REFRESH_N clocks.
- **Scan order:** 0 → 1 → 2 → 3 → 0. The wrap from idx 3 to 0 passes through the same blank cycle.
- **Blink period:** 2^BLINK_N clocks, 50 % duty, phase-independent of the scan.
- **Simultaneous events:**
  - A flag change during the blank cycle takes effect on the next active cycle.
  - A `blink` toggle mid-slot changes idx 1 immediately; a partial-slot flicker is accepted.
- **Outputs are glitch-free:** every output comes straight from a flop.

## Test plan
All scenarios use REFRESH_N = 3 and BLINK_N = 5.
- **Reset:** hold `rst_i` = 0 for 5 clocks → `an_o` = 1111, `seg_o` = 7F, `dp_o` = 1 throughout. Release → at the first edge `an_o` = 1110.
- **Scan cadence:** `wdat_i` = 3, `rdat_i` = A, `full_i` = 0, `empty_i` = 1, after settling →
  - `an_o` steps 1110 → 1101 → 1011 → 0111.
  - Each slot is 7 active clocks followed by 1 clock of 1111.
  - `seg_o` per slot: 06 (E), 7F (blank), 08 (A), 30 (3).
- **Full blink:** `full_i` = 1, `empty_i` = 0 → during idx 1, `seg_o` = 0E while `bcnt[4]` = 0 and 7F while `bcnt[4]` = 1. Digit 0 is blank.
- **Latency:** with digit 3 active, change `wdat_i` from 3 to 7 → `seg_o` changes 30 → 78 exactly 3 clocks later.
- **Illegal flags:** `full_i` = `empty_i` = 1 → `dp_o` = 0 only while `an_o` = 1011. Digit 0 shows 06 and digit 1 blinks 0E.
- **Mid-slot reset:** assert `rst_i` = 0 asynchronously mid-slot while idx = 2 → outputs go to 1111/7F/1 without waiting for a clock edge. After release, the scan restarts at idx 0.
